serial_adder_arbiter: RTL
=========================

Name: serial_adder_arbiter

Overview:
- Time-shares one bit-serial full-adder datapath between two requesters.
- Round-robin arbitration picks a requester; its operands and carry-in are captured at grant.
- The operands are then summed LSB-first, one bit per clock, through a single full-adder cell.
- The WIDTH-bit sum and carry-out are returned with a one-cycle response strobe and the winner's ID.
- Sits between the adder phase sequencer and the blocks that need additions.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- CLK  input  1  clock, rising edge.
- NRST  input  1  reset, asynchronous, active-low.
- abort  input  1  synchronous cancel, active-high.
- req  input  2  request lines; req[i] for requester i, held until gnt[i].
- opa0  input  WIDTH  requester 0 operand A.
- opb0  input  WIDTH  requester 0 operand B.
- cin0  input  1  requester 0 carry-in.
- opa1  input  WIDTH  requester 1 operand A.
- opb1  input  WIDTH  requester 1 operand B.
- cin1  input  1  requester 1 carry-in.
- gnt  output  2  one-hot grant, one-cycle pulse.
- busy  output  1  high whenever state is not IDLE.
- rsp_valid  output  1  one-cycle result strobe.
- rsp_id  output  1  requester ID of the current result.
- sum  output  WIDTH  result sum.
- cout  output  1  result carry-out.

Behaviour:
- Reset values: state=IDLE, gnt=0, busy=0, rsp_valid=0, rsp_id=0, sum=0, cout=0, rr_last=1 (requester 0 wins first).
- NRST assertion at any time, including mid-shift, forces all of the above immediately.
- States, 2-bit encoding: IDLE=00, SHIFT=01, DONE=10. Code 11 is illegal and returns to IDLE next edge.
- IDLE, req!=0, abort=0, sampled at edge k:
  - Winner is the requester other than rr_last if it is requesting, else the only requester.
  - Captures the winner's opa/opb into shift regs A_sr/B_sr and its cin into carry_q; cnt=0.
  - rr_last=winner; gnt[winner]=1 during cycle k+1 only; state=SHIFT.
- SHIFT, each edge:
  - full_adder_cell(A_sr[0], B_sr[0], carry_q) produces s, c.
  - s is shifted into S_sr at the MSB (S_sr shifts right); carry_q=c; A_sr and B_sr shift right; cnt++.
  - At the edge where cnt==WIDTH-1: sum=final S_sr, cout=c, rsp_id=rr_last, rsp_valid=1, state=DONE.
- Latency: rsp_valid is high in the cycle after edge k+WIDTH, i.e. WIDTH cycles after the gnt cycle.
- DONE: rsp_valid high for this one cycle; next edge goes to IDLE. Requests are not sampled in DONE.
- Back-to-back throughput: one result per WIDTH+2 cycles.
- sum, cout and rsp_id hold their values until the next completed result.
- abort:
  - In SHIFT or DONE: state=IDLE at the next edge. No rsp_valid in SHIFT; a DONE strobe already in progress is not retracted.
  - Output registers keep their previous result. rr_last is not restored, so the aborted requester loses its turn.
  - In IDLE, abort has priority over req: no grant that edge.
- Requests arriving while busy are ignored (no queueing). Requesters keep req high and are served in the next IDLE.
- Arithmetic: {cout,sum} = opa + opb + cin, modulo 2^(WIDTH+1); no sign handling.
- busy is combinational from state; gnt and rsp_valid are registered.

Decomposition:
- Package serial_adder_pkg holds:
  - state encodings ST_IDLE/ST_SHIFT/ST_DONE;
  - default WIDTH;
  - requester ID constants REQ0=0, REQ1=1.
- Sub-module full_adder_cell (a, b, cin -> s, cout), purely combinational. Reused by the phase sequencer.
- Arbiter, sequencer FSM and shift registers stay in the top module.

Test Plan:
- req0 with opa0=8'h5A, opb0=8'h3C, cin0=0 -> gnt=2'b01 for 1 cycle; 8 cycles later rsp_valid=1, sum=8'h96, cout=0, rsp_id=0.
- Overflow and carry-in:
  - opa0=8'hFF, opb0=8'h01, cin0=0 -> sum=8'h00, cout=1.
  - opa1=8'h7F, opb1=8'h00, cin1=1 -> sum=8'h80, cout=0, rsp_id=1.
- req=2'b11 held continuously -> grants alternate 01,10,01,10; each rsp_id matches its grant; gnt spacing is exactly 10 cycles.
- abort pulsed on the 3rd SHIFT cycle -> busy drops next cycle, no rsp_valid, sum/cout keep the prior result. A following req=2'b11 grants the non-aborted requester.
- NRST pulsed mid-SHIFT -> all outputs 0 immediately. The next req=2'b11 grants requester 0 first.
- Random regression: 1000 random operand/cin/req/abort sequences, checked against a {cout,sum}=a+b+cin reference model plus a grant-fairness check (never the same requester twice while the other is waiting).

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder blocks: sequencer state codes,
// default operand width and requester IDs.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/serial_adder_arbiter_fa.sv
// Single-bit full adder used as the serial datapath cell; kept separate so the
// phase sequencer can reuse the same cell.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_arbiter.sv
// Two-requester round-robin front end for one bit-serial full adder: operands
// are captured at grant and summed LSB-first, one bit per clock.
module serial_adder_arbiter
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             abort,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] opa0,
  input  logic [WIDTH-1:0] opb0,
  input  logic             cin0,
  input  logic [WIDTH-1:0] opa1,
  input  logic [WIDTH-1:0] opb1,
  input  logic             cin1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic             rr_last;
  logic             winner;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] s_next;

  // The requester that did not win last time has priority when both ask.
  always_comb begin
    if (rr_last == REQ1) winner = req[0] ? REQ0 : REQ1;
    else                 winner = req[1] ? REQ1 : REQ0;
  end

  full_adder_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign s_next = {fa_s, s_sr[WIDTH-1:1]};
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state     <= ST_IDLE;
      rr_last   <= REQ1;
      gnt       <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      s_sr      <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
    end else begin
      gnt       <= 2'b00;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!abort && (req != 2'b00)) begin
            a_sr    <= (winner == REQ1) ? opa1 : opa0;
            b_sr    <= (winner == REQ1) ? opb1 : opb0;
            carry_q <= (winner == REQ1) ? cin1 : cin0;
            cnt     <= '0;
            rr_last <= winner;
            gnt     <= (winner == REQ1) ? 2'b10 : 2'b01;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            s_sr    <= s_next;
            carry_q <= fa_c;
            cnt     <= cnt + 1'b1;
            if (cnt == LAST_BIT) begin
              sum       <= s_next;
              cout      <= fa_c;
              rsp_id    <= rr_last;
              rsp_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
